// File: rtl/stream_dmux.sv
// rtl/stream_dmux.sv - registered valid/ready demultiplexer with per-channel FIFOs and broadcast
module stream_dmux #(
    parameter int BUS_WIDTH = 8,
    parameter int CHANNELS  = 4,
    parameter int SEL_WIDTH = $clog2(CHANNELS),
    parameter int DEPTH     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BUS_WIDTH-1:0]          in_data,
    input  logic [SEL_WIDTH-1:0]          in_sel,
    input  logic                          in_bcast,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [CHANNELS*BUS_WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]           out_valid,
    input  logic [CHANNELS-1:0]           out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [BUS_WIDTH-1:0] r_mem    [CHANNELS][DEPTH];
    logic [PW-1:0]        r_rd_ptr [CHANNELS];
    logic [PW-1:0]        r_wr_ptr [CHANNELS];
    logic [CW-1:0]        r_count  [CHANNELS];
    // Registered head of each channel; keeps the last popped value while the FIFO is empty
    logic [BUS_WIDTH-1:0] r_head   [CHANNELS];

    logic [CHANNELS-1:0]  w_full;
    logic [CHANNELS-1:0]  w_push;
    logic [CHANNELS-1:0]  w_pop;
    logic                 w_accept;
    logic [PW-1:0]        w_rd_next   [CHANNELS];
    logic [CW-1:0]        w_cnt_next  [CHANNELS];
    logic [BUS_WIDTH-1:0] w_head_next [CHANNELS];

    // Fullness and validity from registered counts only; broadcast needs room everywhere
    always_comb begin
        w_full    = '0;
        out_valid = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_full[k]    = (r_count[k] == CW'(DEPTH));
            out_valid[k] = (r_count[k] != '0);
        end
        in_ready = in_bcast ? ~|w_full : ~w_full[in_sel];
        w_accept = in_valid & in_ready;
    end

    // Per-channel push/pop decode and next pointer, count and head values
    always_comb begin
        w_push = '0;
        w_pop  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_push[k]      = w_accept & (in_bcast | (in_sel == SEL_WIDTH'(k)));
            w_pop[k]       = out_valid[k] & out_ready[k];
            w_rd_next[k]   = w_pop[k] ? r_rd_ptr[k] + PW'(1) : r_rd_ptr[k];
            w_cnt_next[k]  = r_count[k] + CW'(w_push[k]) - CW'(w_pop[k]);
            // The slot being written becomes the head only when it is the sole entry left
            w_head_next[k] = (w_push[k] && (r_wr_ptr[k] == w_rd_next[k])) ?
                             in_data : r_mem[k][w_rd_next[k]];
        end
    end

    // Flatten the registered heads onto the output bus
    always_comb begin
        out_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            out_data[k*BUS_WIDTH +: BUS_WIDTH] = r_head[k];
        end
    end

    // FIFO state; reset discards every buffered entry and clears storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_rd_ptr[k] <= '0;
                r_wr_ptr[k] <= '0;
                r_count[k]  <= '0;
                r_head[k]   <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    r_mem[k][d] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (w_push[k]) begin
                    r_mem[k][r_wr_ptr[k]] <= in_data;
                    r_wr_ptr[k]           <= r_wr_ptr[k] + PW'(1);
                end
                r_rd_ptr[k] <= w_rd_next[k];
                r_count[k]  <= w_cnt_next[k];
                if (w_cnt_next[k] != '0) begin
                    r_head[k] <= w_head_next[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_dmux.sv
// tb/tb_stream_dmux.sv - scoreboard bench for stream_dmux with directed vectors
module tb_stream_dmux;

    localparam int BW = 8;
    localparam int CH = 4;
    localparam int SW = 2;
    localparam int DP = 2;

    logic          clk;
    logic          rst_n;
    logic [BW-1:0] in_data;
    logic [SW-1:0] in_sel;
    logic          in_bcast;
    logic          in_valid;
    logic          in_ready;
    logic [CH*BW-1:0] out_data;
    logic [CH-1:0] out_valid;
    logic [CH-1:0] out_ready;

    int n_vec  = 0;
    int n_miss = 0;
    bit sb_en  = 0;
    logic [BW-1:0] exp_q [CH][$];

    stream_dmux #(.BUS_WIDTH(BW), .CHANNELS(CH), .DEPTH(DP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_bcast (in_bcast),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Monitor pops and compares on every handshake, then records newly accepted inputs
    always @(negedge clk) begin
        if (rst_n && sb_en) begin
            for (int k = 0; k < CH; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    n_vec++;
                    if (exp_q[k].size() == 0) begin
                        n_miss++;
                        $display("FAIL unexpected_out ch%0d got %h expected nothing", k, out_data[k*BW +: BW]);
                    end else begin
                        logic [BW-1:0] e;
                        e = exp_q[k].pop_front();
                        if (out_data[k*BW +: BW] !== e) begin
                            n_miss++;
                            $display("FAIL out_data ch%0d got %h expected %h", k, out_data[k*BW +: BW], e);
                        end
                    end
                end
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k < CH; k++) begin
                    if (in_bcast || in_sel == SW'(k)) exp_q[k].push_back(in_data);
                end
            end
        end
    end

    always @(negedge rst_n) begin
        for (int k = 0; k < CH; k++) exp_q[k].delete();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [SW-1:0] sel, input logic bc, input logic [BW-1:0] d);
        in_sel = sel; in_bcast = bc; in_data = d; in_valid = 1'b1;
    endtask

    // Hold a transfer until accepted, bounded; returns at posedge+1 after the accepting edge
    task automatic push(input logic [SW-1:0] sel, input logic bc, input logic [BW-1:0] d);
        bit done;
        done = 0;
        drive(sel, bc, d);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            n_vec++; n_miss++;
            $display("FAIL push_timeout got in_ready=0 expected acceptance of %h", d);
        end
    endtask

    initial begin
        rst_n = 1; in_valid = 0; in_bcast = 0; in_sel = 0; in_data = 0; out_ready = '1;

        // 1. reset asserted mid-cycle with random inputs
        #13;
        in_valid = 1; in_data = 8'hC3;
        rst_n = 0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        for (int i = 0; i < 4; i++) begin
            in_sel = SW'($urandom_range(0, 3)); in_bcast = 1'($urandom_range(0, 1));
            #1;
            chk("rst_in_ready", 32'(in_ready), 32'h1);
        end
        in_valid = 0; in_bcast = 0;
        tick(); tick();
        rst_n = 1; sb_en = 1;
        tick(); tick(); tick();
        chk("idle_out_valid", 32'(out_valid), 32'h0);
        chk("idle_out_data", out_data, 32'h0);
        chk("idle_in_ready", 32'(in_ready), 32'h1);

        // 2. routing, each entry visible one cycle after its accept
        for (int i = 0; i < 4; i++) begin
            drive(SW'(i), 0, 8'(8'h10 + 8'h11 * i));
            tick();
            chk("route_onehot", 32'(out_valid), 32'(4'b0001 << i));
        end
        in_valid = 0;
        tick();
        chk("route_drained", 32'(out_valid), 32'h0);

        // 3. backpressure on ch2 does not block ch1
        out_ready = 4'b1011;
        drive(2, 0, 8'hA0); tick();
        drive(2, 0, 8'hA1); tick();
        drive(2, 0, 8'hA2); #1;
        chk("bp_full_ready", 32'(in_ready), 32'h0);
        in_valid = 0;
        drive(1, 0, 8'h55); #1;
        chk("bp_other_ready", 32'(in_ready), 32'h1);
        tick();
        chk("bp_ch1_valid", 32'(out_valid), 32'b0110);
        drive(2, 0, 8'hA2); #1;
        chk("bp_hold_ready", 32'(in_ready), 32'h0);
        tick();
        chk("bp_still_blocked", 32'(in_ready), 32'h0);
        out_ready[2] = 1'b1;
        tick();
        chk("bp_ready_after_pop", 32'(in_ready), 32'h1);
        tick();
        in_valid = 0;
        repeat (3) tick();
        chk("bp_drained", 32'(out_valid), 32'h0);

        // 4. broadcast, then all-or-nothing against a full ch3
        out_ready = 4'b1111;
        drive(0, 1, 8'h5A); tick();
        in_valid = 0;
        chk("bc_valid", 32'(out_valid), 32'hF);
        chk("bc_data", out_data, 32'h5A5A5A5A);
        tick();
        out_ready = 4'b0111;
        drive(3, 0, 8'h31); tick();
        drive(3, 0, 8'h32); tick();
        drive(0, 1, 8'h66); #1;
        chk("bc_blocked_ready", 32'(in_ready), 32'h0);
        tick();
        chk("bc_no_write", 32'(out_valid), 32'b1000);
        out_ready[3] = 1'b1;
        tick();
        chk("bc_ready_after_pop", 32'(in_ready), 32'h1);
        tick();
        in_valid = 0;
        chk("bc_all_valid", 32'(out_valid), 32'hF);
        chk("bc_all_data", out_data, 32'h66666666);
        repeat (2) tick();

        // 5. simultaneous push/pop at count 1, then wrap-around
        out_ready = 4'b1110;
        drive(0, 0, 8'h01); tick();
        in_valid = 0;
        out_ready[0] = 1'b1;
        drive(0, 0, 8'h02); tick();
        in_valid = 0;
        chk("pp_valid", 32'(out_valid[0]), 32'h1);
        chk("pp_head", 32'(out_data[7:0]), 32'h02);
        tick();
        chk("pp_empty", 32'(out_valid[0]), 32'h0);
        chk("pp_hold_last", 32'(out_data[7:0]), 32'h02);
        fork
            begin
                for (int i = 0; i < 2*DP+1; i++) push(0, 0, 8'(8'hB0 + i));
            end
            begin
                logic [11:0] pat;
                pat = 12'b1101_0010_0100;
                for (int i = 0; i < 12; i++) begin
                    out_ready[0] = pat[i];
                    tick();
                end
                out_ready[0] = 1'b1;
            end
        join
        repeat (4) tick();
        chk("wrap_drained", 32'(exp_q[0].size()), 32'h0);

        // 6. reset during traffic discards buffered entries
        out_ready = 4'b1101;
        drive(1, 0, 8'h70); tick();
        drive(1, 0, 8'h71); tick();
        drive(1, 0, 8'h72);
        #2;
        chk("rt_pre_valid", 32'(out_valid[1]), 32'h1);
        rst_n = 0;
        #1;
        chk("rt_valid_cleared", 32'(out_valid), 32'h0);
        chk("rt_ready", 32'(in_ready), 32'h1);
        in_valid = 0;
        tick();
        rst_n = 1;
        out_ready = 4'b1111;
        tick();
        drive(1, 0, 8'h77); tick();
        in_valid = 0;
        chk("rt_new_valid", 32'(out_valid), 32'b0010);
        chk("rt_new_head", 32'(out_data[15:8]), 32'h77);
        repeat (3) tick();
        for (int k = 0; k < CH; k++) chk("final_queue_empty", 32'(exp_q[k].size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
